// File: rtl/uart_arb_pkg.sv
// Shared types, widths and the round-robin pick function for the uart_tx arbiter.
package uart_arb_pkg;

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned MAX_REQ = 8;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned NUM_W   = IDX_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STROBE,
        WAIT_ACK,
        WAIT_DONE,
        RELEASE
    } arb_state_e;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // First valid index at or above ptr, wrapping modulo num.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                      input logic [IDX_W-1:0]   ptr,
                                      input logic [NUM_W-1:0]   num);
        pick_t            res;
        logic [NUM_W-1:0] j;
        res = '0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            j = {1'b0, ptr} + NUM_W'(k);
            if (j >= num) begin
                j = j - num;
            end
            if (!res.found && (NUM_W'(k) < num) && valid[j[IDX_W-1:0]]) begin
                res.found = 1'b1;
                res.idx   = j[IDX_W-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte stream plus uart_tx strobe/busy hookup.
interface uart_tx_arbiter_if
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [BYTE_W*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        req_ready;
    logic [BYTE_W-1:0]         tx_data;
    logic                      tx_pluse;
    logic                      tx_busy;

    modport slave (
        input  req_valid, req_data, req_last, tx_busy,
        output req_ready, tx_data, tx_pluse
    );

    modport master (
        output req_valid, req_data, req_last, tx_busy,
        input  req_ready, tx_data, tx_pluse
    );
endinterface

// File: rtl/uart_arb_rr_pick.sv
// Combinational rotate-and-priority-encode used by the arbiter in IDLE.
module uart_arb_rr_pick
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic               found_c,
    output logic [IDX_W-1:0]   idx_c
);
    pick_t pick_c;

    // Widen to the package's fixed search width and pick.
    always_comb begin
        pick_c = rr_pick(MAX_REQ'(valid), ptr, NUM_W'(NUM_REQ));
    end

    assign found_c = pick_c.found;
    assign idx_c   = pick_c.idx;
endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between NUM_REQ requesters with packet-granular grants.
// Define UART_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins)
// instead of round-robin.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned MAX_PKT_LEN = 32,
    parameter int unsigned ACK_TMO     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    uart_tx_arbiter_if.slave           bus,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       grant_active,
    output logic                       pkt_done,
    output logic                       tx_err
);
    localparam int unsigned GID_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = 8;
    localparam int unsigned TMR_W = 8;

    arb_state_e         state_q, state_d;
    logic [GID_W-1:0]   grant_id_d;
    logic               grant_active_d, pkt_done_d, tx_err_d;
    logic [NUM_REQ-1:0] req_ready_d;
    logic [BYTE_W-1:0]  tx_data_d;
    logic               tx_pluse_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic               last_q, last_d;

    logic               own_valid_c, own_last_c, pkt_end_c;
    logic [BYTE_W-1:0]  own_data_c;
    logic [IDX_W-1:0]   pick_ptr, pick_idx_c;
    logic               pick_found_c;

`ifdef UART_ARB_FIXED_PRIO_EN
    assign pick_ptr = '0;
`else
    logic [GID_W-1:0] rr_ptr_q;

    // Round-robin pointer moves past the owner on every release.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else if (state_q == RELEASE) begin
            rr_ptr_q <= (grant_id == GID_W'(NUM_REQ - 1)) ? '0 : grant_id + GID_W'(1);
        end
    end

    assign pick_ptr = IDX_W'(rr_ptr_q);
`endif

    uart_arb_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .valid   (bus.req_valid),
        .ptr     (pick_ptr),
        .found_c (pick_found_c),
        .idx_c   (pick_idx_c)
    );

    assign own_valid_c = bus.req_valid[grant_id];
    assign own_last_c  = bus.req_last[grant_id];
    assign own_data_c  = bus.req_data[BYTE_W*int'(grant_id) +: BYTE_W];
    assign pkt_end_c   = last_q || (cnt_q == CNT_W'(MAX_PKT_LEN));

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_id      <= '0;
            grant_active  <= 1'b0;
            pkt_done      <= 1'b0;
            tx_err        <= 1'b0;
            bus.req_ready <= '0;
            bus.tx_data   <= '0;
            bus.tx_pluse  <= 1'b0;
            cnt_q         <= '0;
            tmr_q         <= '0;
            last_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_id      <= grant_id_d;
            grant_active  <= grant_active_d;
            pkt_done      <= pkt_done_d;
            tx_err        <= tx_err_d;
            bus.req_ready <= req_ready_d;
            bus.tx_data   <= tx_data_d;
            bus.tx_pluse  <= tx_pluse_d;
            cnt_q         <= cnt_d;
            tmr_q         <= tmr_d;
            last_q        <= last_d;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_d        = state_q;
        grant_id_d     = grant_id;
        grant_active_d = grant_active;
        pkt_done_d     = 1'b0;
        tx_err_d       = tx_err;
        req_ready_d    = '0;
        tx_data_d      = bus.tx_data;
        tx_pluse_d     = 1'b0;
        cnt_d          = cnt_q;
        tmr_d          = tmr_q;
        last_d         = last_q;

        unique case (state_q)
            IDLE: begin
                if (!bus.tx_busy && pick_found_c) begin
                    grant_id_d     = GID_W'(pick_idx_c);
                    grant_active_d = 1'b1;
                    state_d        = LOAD;
                end
            end
            LOAD: begin
                if (own_valid_c) begin
                    req_ready_d[grant_id] = 1'b1;
                    tx_data_d             = own_data_c;
                    last_d                = own_last_c;
                    if (cnt_q != CNT_W'(MAX_PKT_LEN)) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    state_d = STROBE;
                end
            end
            STROBE: begin
                tx_pluse_d = 1'b1;
                tmr_d      = '0;
                state_d    = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (bus.tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (tmr_q == TMR_W'(ACK_TMO - 1)) begin
                    tx_err_d = 1'b1;
                    state_d  = pkt_end_c ? RELEASE : LOAD;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    state_d = pkt_end_c ? RELEASE : LOAD;
                end
            end
            RELEASE: begin
                pkt_done_d     = 1'b1;
                grant_active_d = 1'b0;
                cnt_d          = '0;
                last_d         = 1'b0;
                state_d        = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with requester queues and a uart_tx busy model.
module tb_uart_tx_arbiter;
    import uart_arb_pkg::*;

    localparam int unsigned NREQ     = 4;
    localparam int unsigned MAXP     = 4;
    localparam int unsigned TMO      = 8;
    localparam int          BUSY_LEN = 20;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [$clog2(NREQ)-1:0] grant_id;
    logic                    grant_active, pkt_done, tx_err;

    uart_tx_arbiter_if #(.NUM_REQ(NREQ)) bus ();

    uart_tx_arbiter #(.NUM_REQ(NREQ), .MAX_PKT_LEN(MAXP), .ACK_TMO(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .grant_id     (grant_id),
        .grant_active (grant_active),
        .pkt_done     (pkt_done),
        .tx_err       (tx_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [8:0]      rq [NREQ][$];
    logic [NREQ-1:0] en = '1;
    int              vrise [NREQ];
    logic            ack_en = 1'b1;
    int              busy_cnt = 0;
    int              bf_cyc [$];
    logic [7:0]      p_data [$];
    int              p_gid [$];
    int              p_cyc [$];
    int              rdy_cnt [NREQ];
    int              done_cnt = 0;
    int              viol = 0;
    int              err_rise_cyc = -1;
    int              grant_rise_cyc = -1;
    logic            prev_err = 1'b0;
    logic            prev_ga = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor, uart_tx busy model and requester sources, all on the falling edge.
    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        bus.tx_busy   = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.tx_pluse) begin
                p_data.push_back(bus.tx_data);
                p_gid.push_back(int'(grant_id));
                p_cyc.push_back(cyc);
            end
            if (pkt_done) done_cnt++;
            if (bus.req_ready != '0 &&
                (!grant_active || bus.req_ready != (NREQ'(1) << grant_id))) viol++;
            if (tx_err && !prev_err) err_rise_cyc = cyc;
            if (grant_active && !prev_ga) grant_rise_cyc = cyc;
            prev_err = tx_err;
            prev_ga  = grant_active;

            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) begin
                    bus.tx_busy = 1'b0;
                    bf_cyc.push_back(cyc);
                end
            end
            if (bus.tx_pluse && ack_en) begin
                bus.tx_busy = 1'b1;
                busy_cnt    = BUSY_LEN;
            end

            for (int i = 0; i < NREQ; i++) begin
                if (bus.req_ready[i]) begin
                    rdy_cnt[i]++;
                    if (rq[i].size() > 0) void'(rq[i].pop_front());
                end
                if (en[i] && rq[i].size() > 0) begin
                    if (!bus.req_valid[i]) vrise[i] = cyc;
                    bus.req_valid[i]        = 1'b1;
                    bus.req_data[8*i +: 8]  = rq[i][0][7:0];
                    bus.req_last[i]         = rq[i][0][8];
                end else begin
                    bus.req_valid[i] = 1'b0;
                    bus.req_last[i]  = 1'b0;
                end
            end
        end
    end

    task automatic clear_logs();
        p_data.delete();
        p_gid.delete();
        p_cyc.delete();
        bf_cyc.delete();
        for (int i = 0; i < NREQ; i++) rdy_cnt[i] = 0;
        done_cnt       = 0;
        err_rise_cyc   = -1;
        grant_rise_cyc = -1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_done(input int n, input int budget);
        while (done_cnt < n && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
    endtask

    task automatic wait_pulses(input int n, input int budget);
        while (p_data.size() < n && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
    endtask

    task automatic wait_quiet();
        int budget = 100;
        while (bus.tx_busy && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_chk++;
        if ({grant_active, pkt_done, tx_err, bus.tx_pluse} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_flags got=%b want=0000", {grant_active, pkt_done, tx_err, bus.tx_pluse});
        end
        n_chk++;
        if (bus.tx_data !== 8'h00 || bus.req_ready !== 4'b0000 || grant_id !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_bus got data=%h ready=%b gid=%0d want 0", bus.tx_data, bus.req_ready, grant_id);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [7:0] exp [3] = '{8'h41, 8'h42, 8'h43};
        do_reset();
        clear_logs();
        rq[0].push_back(9'h041);
        rq[0].push_back(9'h042);
        rq[0].push_back(9'h143);
        wait_done(1, 400);
        wait_quiet();
        n_chk++;
        if (p_data.size() != 3) begin
            n_bad++;
            $display("FAIL single_count got=%0d want=3", p_data.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_chk++;
                if (p_data[i] !== exp[i] || p_gid[i] != 0) begin
                    n_bad++;
                    $display("FAIL single_byte%0d got=%h/gid%0d want=%h/gid0", i, p_data[i], p_gid[i], exp[i]);
                end
            end
            n_chk++;
            if (p_cyc[0] - vrise[0] != 3) begin
                n_bad++;
                $display("FAIL single_latency got=%0d want=3", p_cyc[0] - vrise[0]);
            end
            n_chk++;
            if (bf_cyc.size() < 1 || p_cyc[1] - bf_cyc[0] != 3) begin
                n_bad++;
                $display("FAIL single_b2b got=%0d want=3", (bf_cyc.size() > 0) ? p_cyc[1] - bf_cyc[0] : -1);
            end
        end
        n_chk++;
        if (rdy_cnt[0] != 3 || done_cnt != 1) begin
            n_bad++;
            $display("FAIL single_ready_done got=%0d/%0d want=3/1", rdy_cnt[0], done_cnt);
        end
    endtask

    task automatic test_contention();
        logic [7:0] exp_d [4] = '{8'h11, 8'h12, 8'h21, 8'h22};
        int         exp_g [4] = '{1, 1, 2, 2};
        do_reset();
        clear_logs();
        rq[1].push_back(9'h011);
        rq[1].push_back(9'h112);
        rq[2].push_back(9'h021);
        rq[2].push_back(9'h122);
        wait_done(2, 500);
        wait_quiet();
        n_chk++;
        if (p_data.size() != 4) begin
            n_bad++;
            $display("FAIL contend_count got=%0d want=4", p_data.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_chk++;
                if (p_data[i] !== exp_d[i] || p_gid[i] != exp_g[i]) begin
                    n_bad++;
                    $display("FAIL contend_byte%0d got=%h/gid%0d want=%h/gid%0d", i, p_data[i], p_gid[i], exp_d[i], exp_g[i]);
                end
            end
        end
        clear_logs();
        rq[0].push_back(9'h101);
        rq[3].push_back(9'h131);
        wait_done(2, 300);
        wait_quiet();
        n_chk++;
        if (p_data.size() != 2 || p_data[0] !== 8'h31 || p_gid[0] != 3 || p_data[1] !== 8'h01 || p_gid[1] != 0) begin
            n_bad++;
            $display("FAIL contend_ptr3 got n=%0d first=%h want n=2 first=31 then 01", p_data.size(),
                     (p_data.size() > 0) ? p_data[0] : 8'hxx);
        end
    endtask

    task automatic test_fairness();
        logic [7:0] exp_d [11] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'h3F, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA8, 8'hA9};
        int         exp_g [11] = '{0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0};
        do_reset();
        clear_logs();
        for (int i = 0; i < 10; i++) rq[0].push_back({1'b0, 8'hA0 + 8'(i)});
        rq[3].push_back(9'h13F);
        wait_pulses(11, 900);
        wait_quiet();
        n_chk++;
        if (p_data.size() != 11) begin
            n_bad++;
            $display("FAIL fair_count got=%0d want=11", p_data.size());
        end else begin
            for (int i = 0; i < 11; i++) begin
                n_chk++;
                if (p_data[i] !== exp_d[i] || p_gid[i] != exp_g[i]) begin
                    n_bad++;
                    $display("FAIL fair_byte%0d got=%h/gid%0d want=%h/gid%0d", i, p_data[i], p_gid[i], exp_d[i], exp_g[i]);
                end
            end
        end
        n_chk++;
        if (done_cnt != 3 || grant_active !== 1'b1 || grant_id !== 2'd0) begin
            n_bad++;
            $display("FAIL fair_release got done=%0d ga=%b gid=%0d want done=3 ga=1 gid=0", done_cnt, grant_active, grant_id);
        end
    endtask

    task automatic test_stall();
        int snap;
        int ga_low = 0;
        do_reset();
        clear_logs();
        rq[2].push_back(9'h051);
        rq[2].push_back(9'h052);
        rq[2].push_back(9'h153);
        wait_pulses(1, 100);
        en[2] = 1'b0;
        snap  = p_data.size();
        repeat (50) begin
            @(posedge clk);
            #1;
            if (grant_active !== 1'b1) ga_low++;
        end
        n_chk++;
        if (ga_low != 0 || p_data.size() != snap || snap != 1) begin
            n_bad++;
            $display("FAIL stall_gap got ga_low=%0d pulses=%0d want 0 and 1", ga_low, p_data.size());
        end
        en[2] = 1'b1;
        wait_done(1, 300);
        wait_quiet();
        n_chk++;
        if (p_data.size() != 3 || p_data[1] !== 8'h52 || p_data[2] !== 8'h53 || p_gid[2] != 2) begin
            n_bad++;
            $display("FAIL stall_resume got n=%0d want n=3 bytes 51 52 53 gid2", p_data.size());
        end
    endtask

    task automatic test_lost_ack();
        do_reset();
        clear_logs();
        ack_en = 1'b0;
        rq[1].push_back(9'h061);
        rq[1].push_back(9'h162);
        wait_done(1, 200);
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if (tx_err !== 1'b1 || done_cnt != 1) begin
            n_bad++;
            $display("FAIL lost_err got err=%b done=%0d want err=1 done=1", tx_err, done_cnt);
        end
        n_chk++;
        if (p_data.size() != 2 || err_rise_cyc - p_cyc[0] != 8) begin
            n_bad++;
            $display("FAIL lost_tmo got n=%0d delay=%0d want n=2 delay=8", p_data.size(),
                     (p_data.size() > 0) ? err_rise_cyc - p_cyc[0] : -1);
        end else begin
            n_chk++;
            if (p_data[1] !== 8'h62 || p_cyc[1] - p_cyc[0] != 10) begin
                n_bad++;
                $display("FAIL lost_next got=%h gap=%0d want=62 gap=10", p_data[1], p_cyc[1] - p_cyc[0]);
            end
        end
        ack_en = 1'b1;
        do_reset();
        n_chk++;
        if (tx_err !== 1'b0) begin
            n_bad++;
            $display("FAIL lost_clear got err=%b want=0", tx_err);
        end
    endtask

    task automatic test_reset_mid();
        int budget = 100;
        int snap;
        int ga_bad = 0;
        do_reset();
        clear_logs();
        rq[0].push_back(9'h071);
        rq[0].push_back(9'h172);
        while (!bus.tx_busy && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        repeat (3) @(posedge clk);
        #1;
        snap = done_cnt;
        rst  = 1'b1;
        @(posedge clk);
        #1;
        n_chk++;
        if ({grant_active, pkt_done, tx_err, bus.tx_pluse} !== 4'b0000 || bus.req_ready !== 4'b0000 ||
            bus.tx_data !== 8'h00 || grant_id !== 2'd0) begin
            n_bad++;
            $display("FAIL rstmid_outputs got ga=%b pd=%b data=%h want all 0", grant_active, pkt_done, bus.tx_data);
        end
        rst    = 1'b0;
        budget = 60;
        while (bus.tx_busy && budget > 0) begin
            if (grant_active) ga_bad++;
            @(posedge clk);
            #1;
            budget--;
        end
        n_chk++;
        if (ga_bad != 0 || done_cnt != snap || budget == 0) begin
            n_bad++;
            $display("FAIL rstmid_hold got early_grant=%0d done=%0d budget=%0d want 0 %0d >0", ga_bad, done_cnt, budget, snap);
        end
        wait_done(1, 200);
        wait_quiet();
        n_chk++;
        if (bf_cyc.size() < 1 || grant_rise_cyc - bf_cyc[0] != 1 || p_data.size() != 2 || p_data[1] !== 8'h72) begin
            n_bad++;
            $display("FAIL rstmid_regrant got n=%0d grant_delay=%0d want n=2 delay=1", p_data.size(),
                     (bf_cyc.size() > 0) ? grant_rise_cyc - bf_cyc[0] : -1);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_stall();
        test_lost_ack();
        test_reset_mid();
        n_chk++;
        if (viol != 0) begin
            n_bad++;
            $display("FAIL ready_onehot got violations=%0d want=0", viol);
        end
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
